mac_col_mk: RTL and testbench

//  Parametrised systolic MAC column holding NKEY key vectors instead of one.

---
 rtl/mac_col_mk.sv | 219 +++++++++++++++++++++
 tb/tb_mac_col_mk.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_col_mk.sv
// mac_col_mk
//   One column of the systolic attention array. Queries travel column to
//   column through q_in/q_out with the instruction and key-select following
//   one cycle behind. During load the column picks its own NKEY keys out of
//   the shared stream by counting load cycles. During execute it produces the
//   dot product of the incoming query with a selected key and can either
//   overwrite or accumulate into its output register.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high
//   q_in       query/key vector from upstream (PR elements of BW bits)
//   q_out      registered query to the downstream column
//   i_inst     [2] accumulate, [1] execute, [0] load
//   i_ksel     key slot used by execute
//   o_inst     i_inst delayed one cycle
//   o_ksel     i_ksel delayed one cycle
//   clr        restart key loading (keys kept until overwritten)
//   out        signed result, BW_ACC bits, wraps on overflow
//   out_vld    out updated this cycle (FIFO write strobe)
//   load_done  all NKEY key slots captured
//
// Timing
//   q_in and clr are consumed in the cycle where the delayed instruction
//   (inst_q) is valid, i.e. one cycle after i_inst. This matches feeding
//   q_in from the upstream q_out and i_inst from the upstream o_inst.
//
// Load sequencer states
//   state   | meaning
//   ST_LOAD | counting load cycles, capturing keys at their stream offsets
//   ST_DONE | last slot captured; lcnt frozen, loads only move query_q

module mac_col_mk #(
    parameter int BW      = 8,
    parameter int PR      = 8,
    parameter int BW_PSUM = 2*BW+3,
    parameter int BW_ACC  = BW_PSUM+4,
    parameter int NCOL    = 8,
    parameter int COL_ID  = 0,
    parameter int NKEY    = 4,
    localparam int KW     = (NKEY > 1) ? $clog2(NKEY) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PR*BW-1:0]  q_in,
    output logic [PR*BW-1:0]  q_out,
    input  logic [2:0]        i_inst,
    input  logic [KW-1:0]     i_ksel,
    output logic [2:0]        o_inst,
    output logic [KW-1:0]     o_ksel,
    input  logic              clr,
    output logic [BW_ACC-1:0] out,
    output logic              out_vld,
    output logic              load_done
);

    // Load counter only has to reach the last slot's offset.
    localparam int LCW  = (NKEY*NCOL > 1) ? $clog2(NKEY*NCOL) : 1;
    localparam int BASE = NCOL - 1 - COL_ID;
    localparam int LAST = BASE + (NKEY - 1) * NCOL;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } load_state_t;

    // Stage 1: instruction / key-select delay
    logic [2:0]        inst_q;
    logic [KW-1:0]     ksel_q;

    // Stage 2: query capture and execute controls
    logic [PR*BW-1:0]  query_q;
    logic [KW-1:0]     ks_q;
    logic              acc_q;
    logic              vld_q1;

    // Stage 3: registered dot product
    logic [BW_PSUM-1:0] psum_q;
    logic               acc_q2;
    logic               vld_q2;

    // Key storage and load sequencer
    logic [PR*BW-1:0]  key_mem [NKEY];
    logic [LCW-1:0]    lcnt;
    logic [LCW-1:0]    lcnt_nxt;
    logic [LCW-1:0]    lcnt_eff;
    load_state_t       state;
    load_state_t       state_nxt;
    logic [NKEY-1:0]   key_wen;

    logic              exec_fire;
    logic [PR*BW-1:0]  key_sel;
    logic signed [2*BW-1:0] prod;
    logic [BW_PSUM-1:0] psum;
    logic [BW_ACC-1:0]  psum_ext;

    assign o_inst    = inst_q;
    assign o_ksel    = ksel_q;
    assign q_out     = query_q;
    assign load_done = (state == ST_DONE);

    // Load has priority: execute only acts when the load bit is clear.
    assign exec_fire = inst_q[1] & ~inst_q[0];

    // ------------------------------------------------------------------
    // Load sequencer: next state, counter and key write enables
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        key_wen   = '0;
        // A clr arriving with a load makes that load count as cycle 0.
        lcnt_eff  = clr ? '0 : lcnt;

        if (clr) begin
            state_nxt = ST_LOAD;
            lcnt_nxt  = '0;
        end

        if (inst_q[0] && (clr || (state == ST_LOAD))) begin
            for (int k = 0; k < NKEY; k++) begin
                if (lcnt_eff == LCW'(BASE + k*NCOL)) begin
                    key_wen[k] = 1'b1;
                end
            end
            if (lcnt_eff == LCW'(LAST)) begin
                state_nxt = ST_DONE;
                lcnt_nxt  = lcnt_eff;
            end else begin
                lcnt_nxt  = lcnt_eff + LCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
            lcnt  <= '0;
            for (int k = 0; k < NKEY; k++) begin
                key_mem[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
            for (int k = 0; k < NKEY; k++) begin
                if (key_wen[k]) begin
                    key_mem[k] <= q_in;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 and stage 2 registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q  <= '0;
            ksel_q  <= '0;
            query_q <= '0;
            ks_q    <= '0;
            acc_q   <= 1'b0;
            vld_q1  <= 1'b0;
        end else begin
            inst_q <= i_inst;
            ksel_q <= i_ksel;
            vld_q1 <= exec_fire;
            if (inst_q[0] || exec_fire) begin
                query_q <= q_in;
            end
            if (exec_fire) begin
                ks_q  <= ksel_q;
                acc_q <= inst_q[2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Dot product of query_q with the selected key. Each product is
    // sign-extended to the full psum width before summing so the worst
    // case (-2^(BW-1))^2 * PR is represented exactly.
    // ------------------------------------------------------------------
    always_comb begin
        key_sel = key_mem[ks_q];
        prod    = '0;
        psum    = '0;
        for (int i = 0; i < PR; i++) begin
            prod = $signed(query_q[i*BW +: BW]) * $signed(key_sel[i*BW +: BW]);
            psum = psum + {{(BW_PSUM-2*BW){prod[2*BW-1]}}, prod};
        end
    end

    assign psum_ext = {{(BW_ACC-BW_PSUM){psum_q[BW_PSUM-1]}}, psum_q};

    // ------------------------------------------------------------------
    // Stage 3 (psum register) and stage 4 (output / accumulator)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            psum_q  <= '0;
            acc_q2  <= 1'b0;
            vld_q2  <= 1'b0;
            out     <= '0;
            out_vld <= 1'b0;
        end else begin
            vld_q2  <= vld_q1;
            out_vld <= vld_q2;
            if (vld_q1) begin
                psum_q <= psum;
                acc_q2 <= acc_q;
            end
            // Accumulation wraps modulo 2^BW_ACC; out holds otherwise.
            if (vld_q2) begin
                out <= acc_q2 ? (out + psum_ext) : psum_ext;
            end
        end
    end

endmodule

// File: tb/tb_mac_col_mk.sv
// Directed testbench for mac_col_mk (BW=8, PR=8, NCOL=8, COL_ID=2, NKEY=2).
// The drive task presents i_inst/i_ksel immediately and the matching q_in/clr
// one cycle later, the way an upstream column would.
module tb_mac_col_mk;

    localparam int BW     = 8;
    localparam int PR     = 8;
    localparam int NCOL   = 8;
    localparam int COL_ID = 2;
    localparam int NKEY   = 2;
    localparam int BW_ACC = 2*BW + 3 + 4;
    localparam int VW     = PR*BW;

    logic              clk;
    logic              reset;
    logic [VW-1:0]     q_in;
    logic [VW-1:0]     q_out;
    logic [2:0]        i_inst;
    logic [0:0]        i_ksel;
    logic [2:0]        o_inst;
    logic [0:0]        o_ksel;
    logic              clr;
    logic [BW_ACC-1:0] out;
    logic              out_vld;
    logic              load_done;

    int checks;
    int errors;

    logic [VW-1:0] nq;
    logic          nclr;

    mac_col_mk #(
        .BW     (BW),
        .PR     (PR),
        .NCOL   (NCOL),
        .COL_ID (COL_ID),
        .NKEY   (NKEY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .q_in      (q_in),
        .q_out     (q_out),
        .i_inst    (i_inst),
        .i_ksel    (i_ksel),
        .o_inst    (o_inst),
        .o_ksel    (o_ksel),
        .clr       (clr),
        .out       (out),
        .out_vld   (out_vld),
        .load_done (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] vfill(input logic [7:0] v);
        return {PR{v}};
    endfunction

    function automatic logic [VW-1:0] ve0(input logic [7:0] v);
        return {{(VW-8){1'b0}}, v};
    endfunction

    task automatic drive(input logic [2:0] inst, input logic [0:0] ksel,
                         input logic [VW-1:0] q, input logic c);
        i_inst = inst;
        i_ksel = ksel;
        q_in   = nq;
        clr    = nclr;
        nq     = q;
        nclr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(3'b000, 1'b0, '0, 1'b0);
    endtask

    task automatic exec1(input logic [0:0] ksel, input logic acc, input logic [VW-1:0] q);
        drive({acc, 2'b10}, ksel, q, 1'b0);
        repeat (3) idle();
    endtask

    // Clear, then stream 16 loads with k0 at offset 5 and k1 at offset 13.
    task automatic load_stream(input logic [VW-1:0] k0, input logic [VW-1:0] k1);
        drive(3'b000, 1'b0, '0, 1'b1);
        idle();
        for (int n = 0; n < 16; n++) begin
            if (n == 5)       drive(3'b001, 1'b0, k0, 1'b0);
            else if (n == 13) drive(3'b001, 1'b0, k1, 1'b0);
            else              drive(3'b001, 1'b0, vfill(8'(100 + n)), 1'b0);
        end
        idle();
    endtask

    task automatic test_reset();
        i_inst = 3'b011;
        i_ksel = 1'b1;
        q_in   = vfill(8'h33);
        clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (q_out !== '0) begin errors++; $display("FAIL reset_q_out: got %0h expected 0", q_out); end
        checks++; if (o_inst !== 3'b000) begin errors++; $display("FAIL reset_o_inst: got %0h expected 0", o_inst); end
        checks++; if (o_ksel !== 1'b0) begin errors++; $display("FAIL reset_o_ksel: got %0h expected 0", o_ksel); end
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %0h expected 0", out); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %0b expected 0", out_vld); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %0b expected 0", load_done); end
        i_inst = '0;
        i_ksel = '0;
        q_in   = '0;
        reset  = 1'b0;
    endtask

    task automatic test_load();
        drive(3'b100, 1'b1, '0, 1'b0);
        checks++; if (o_inst !== 3'b100) begin errors++; $display("FAIL o_inst_delay: got %0h expected 4", o_inst); end
        checks++; if (o_ksel !== 1'b1) begin errors++; $display("FAIL o_ksel_delay: got %0h expected 1", o_ksel); end
        for (int n = 0; n < 16; n++) begin
            drive(3'b001, 1'b0, vfill(8'(n)), 1'b0);
            if (n == 13) begin
                checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL load_done_early: got %0b expected 0", load_done); end
            end
            if (n == 14) begin
                checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_done_rise: got %0b expected 1", load_done); end
                checks++; if (q_out !== vfill(8'd13)) begin errors++; $display("FAIL load_q_out: got %0h expected %0h", q_out, vfill(8'd13)); end
            end
        end
        idle();
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_done_hold: got %0b expected 1", load_done); end
        exec1(1'b0, 1'b0, vfill(8'd1));
        checks++; if (out !== 23'd40) begin errors++; $display("FAIL load_slot0: got %0h expected %0h", out, 23'd40); end
        exec1(1'b1, 1'b0, vfill(8'd1));
        checks++; if (out !== 23'd104) begin errors++; $display("FAIL load_slot1: got %0h expected %0h", out, 23'd104); end
    endtask

    task automatic test_latency();
        load_stream(vfill(8'd1), vfill(8'd1));
        drive(3'b010, 1'b0, vfill(8'd2), 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL latency_early_vld: cycle %0d got %0b expected 0", c, out_vld); end
            idle();
        end
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL latency_vld: got %0b expected 1", out_vld); end
        checks++; if (out !== 23'd16) begin errors++; $display("FAIL latency_out: got %0h expected %0h", out, 23'd16); end
        idle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL latency_vld_pulse: got %0b expected 0", out_vld); end
        checks++; if (out !== 23'd16) begin errors++; $display("FAIL latency_out_hold: got %0h expected %0h", out, 23'd16); end
    endtask

    task automatic test_accumulate();
        logic [BW_ACC-1:0] exp_acc [4];
        exp_acc[0] = 23'd5;
        exp_acc[1] = 23'd2;
        exp_acc[2] = 23'd9;
        exp_acc[3] = 23'd4;
        drive(3'b010, 1'b0, ve0(8'd5), 1'b0);
        drive(3'b110, 1'b0, ve0(8'hFD), 1'b0);
        drive(3'b110, 1'b0, ve0(8'd7), 1'b0);
        drive(3'b010, 1'b0, ve0(8'd4), 1'b0);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) idle();
            checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL acc_vld[%0d]: got %0b expected 1", j, out_vld); end
            checks++; if (out !== exp_acc[j]) begin errors++; $display("FAIL acc_out[%0d]: got %0h expected %0h", j, out, exp_acc[j]); end
        end
    endtask

    task automatic test_wrap();
        load_stream(vfill(8'd1), vfill(8'h80));
        exec1(1'b1, 1'b0, vfill(8'h80));
        checks++; if (out !== 23'd131072) begin errors++; $display("FAIL wrap_psum_max: got %0h expected %0h", out, 23'd131072); end
        exec1(1'b0, 1'b0, ve0(8'hFF));
        checks++; if (out !== 23'h7FFFFF) begin errors++; $display("FAIL wrap_minus1: got %0h expected 7fffff", out); end
        for (int n = 0; n < 32; n++) exec1(1'b1, 1'b1, vfill(8'h80));
        checks++; if (out !== 23'h3FFFFF) begin errors++; $display("FAIL wrap_max: got %0h expected 3fffff", out); end
        exec1(1'b0, 1'b1, ve0(8'd1));
        checks++; if (out !== 23'h400000) begin errors++; $display("FAIL wrap_overflow: got %0h expected 400000", out); end
    endtask

    task automatic test_load_exec_clr();
        logic [VW-1:0] w;
        drive(3'b011, 1'b0, vfill(8'd2), 1'b0);
        for (int c = 0; c < 4; c++) begin
            idle();
            checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL both_no_vld: cycle %0d got %0b expected 0", c, out_vld); end
        end
        checks++; if (out !== 23'h400000) begin errors++; $display("FAIL both_out_hold: got %0h expected 400000", out); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL both_load_done: got %0b expected 1", load_done); end

        drive(3'b000, 1'b0, '0, 1'b1);
        idle();
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL clr_load_done: got %0b expected 0", load_done); end
        for (int n = 0; n < 3; n++) drive(3'b001, 1'b0, vfill(8'(20 + n)), 1'b0);
        for (int j = 0; j < 14; j++) begin
            if (j == 5)       w = vfill(8'd3);
            else if (j == 13) w = vfill(8'hFE);
            else              w = vfill(8'(40 + j));
            drive(3'b001, 1'b0, w, (j == 0));
        end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL clr_refill_early: got %0b expected 0", load_done); end
        idle();
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL clr_refill_done: got %0b expected 1", load_done); end
        exec1(1'b0, 1'b0, vfill(8'd1));
        checks++; if (out !== 23'd24) begin errors++; $display("FAIL clr_slot0: got %0h expected %0h", out, 23'd24); end
        exec1(1'b1, 1'b0, vfill(8'd1));
        checks++; if (out !== 23'h7FFFF0) begin errors++; $display("FAIL clr_slot1: got %0h expected 7ffff0", out); end
    endtask

    task automatic test_reset_midflight();
        drive(3'b010, 1'b0, vfill(8'd1), 1'b0);
        idle();
        idle();
        reset = 1'b1;
        idle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_vld: got %0b expected 0", out_vld); end
        checks++; if (out !== '0) begin errors++; $display("FAIL rst_mid_out: got %0h expected 0", out); end
        checks++; if (q_out !== '0) begin errors++; $display("FAIL rst_mid_q_out: got %0h expected 0", q_out); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_mid_load_done: got %0b expected 0", load_done); end
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            idle();
            checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_stale_vld: cycle %0d got %0b expected 0", c, out_vld); end
        end
        exec1(1'b0, 1'b0, vfill(8'd1));
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL rst_keys_vld: got %0b expected 1", out_vld); end
        checks++; if (out !== '0) begin errors++; $display("FAIL rst_keys_cleared: got %0h expected 0", out); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        i_inst = '0;
        i_ksel = '0;
        q_in   = '0;
        clr    = 1'b0;
        nq     = '0;
        nclr   = 1'b0;

        test_reset();
        test_load();
        test_latency();
        test_accumulate();
        test_wrap();
        test_load_exec_clr();
        test_reset_midflight();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
